// File: rtl/timer_pkg.sv
// Shared types and default widths for the interval timer controller.
package timer_pkg;

  localparam int DIV_W_DEF = 6;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-N prescaler: counts enabled cycles 0..divideby-1 and
// raises go on the last one. The count is held whenever enable is low,
// so a frozen interval resumes without losing or adding clocks.
module tick_prescaler #(
  parameter int DIV_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] divideby,
  output logic             go,
  output logic [DIV_W-1:0] count
);

  assign go = enable && (count == (divideby - DIV_W'(1)));

  // Prescaler count: clear has priority, wrap on go, hold when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= DIV_W'(0);
    end else if (clear) begin
      count <= DIV_W'(0);
    end else if (go) begin
      count <= DIV_W'(0);
    end else if (enable) begin
      count <= count + DIV_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: latches a divide ratio and tick count on an
// accepted start, runs the prescaler and counts its ticks down to zero.
// Supports pause/resume and abort; completion is a one-cycle done pulse.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [DIV_W-1:0] divideby,
  input  logic [CNT_W-1:0] ticks,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] remaining
);

  timer_state_e     state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc_count_unused;
  logic             active;
  logic             presc_enable;
  logic             presc_clear;
  logic             start_bad;

  // RUN and PAUSE both count as an interval in progress. A PAUSE cycle with
  // pause already released is enabled so the resume costs no extra clock.
  assign active       = (state == RUN) || (state == PAUSE);
  assign presc_enable = active && !pause && !abort;
  assign start_bad    = (divideby == DIV_W'(0)) || (ticks == CNT_W'(0));
  assign presc_clear  = ((state == IDLE) && start && !start_bad) || (active && abort);

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (presc_clear),
    .enable   (presc_enable),
    .divideby (div_q),
    .go       (tick),
    .count    (presc_count_unused)
  );

  // Sequencing FSM with registered status outputs and the tick down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_q     <= DIV_W'(0);
      remaining <= CNT_W'(0);
      busy      <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_bad) begin
              err <= 1'b1;
            end else begin
              div_q     <= divideby;
              remaining <= ticks;
              state     <= RUN;
              busy      <= 1'b1;
              paused    <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN, PAUSE: begin
          if (abort) begin
            state     <= IDLE;
            remaining <= CNT_W'(0);
            busy      <= 1'b0;
            paused    <= 1'b0;
          end else if (pause) begin
            state  <= PAUSE;
            busy   <= 1'b1;
            paused <= 1'b1;
          end else if (tick) begin
            if (remaining == CNT_W'(1)) begin
              state     <= DONE;
              remaining <= CNT_W'(0);
              busy      <= 1'b0;
              paused    <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= RUN;
              remaining <= remaining - CNT_W'(1);
              paused    <= 1'b0;
            end
          end else begin
            state  <= RUN;
            paused <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          remaining <= CNT_W'(0);
          busy      <= 1'b0;
          paused    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: stimulus pushes expected
// tick/done/err events; a negedge monitor pops and checks each one.
module tb_interval_timer_ctrl;

  localparam int DW = 6;
  localparam int CW = 8;
  localparam int K_TICK = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          pause;
  logic          abort;
  logic [DW-1:0] divideby;
  logic [CW-1:0] ticks;
  logic          busy;
  logic          paused;
  logic          tick;
  logic          done;
  logic          err;
  logic [CW-1:0] remaining;

  interval_timer_ctrl #(.DIV_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .divideby  (divideby),
    .ticks     (ticks),
    .busy      (busy),
    .paused    (paused),
    .tick      (tick),
    .done      (done),
    .err       (err),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int rem;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(int kind, int c, int rem);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.rem  = rem;
    exp_q.push_back(e);
  endtask

  task automatic observe(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_remaining", int'(remaining), e.rem);
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (err)  observe(K_ERR);
    if (tick) observe(K_TICK);
    if (done) observe(K_DONE);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one interval from cycle 0 (start) to cycle n, checking the
  // busy/paused windows each cycle. Negative cycle numbers disable a control.
  task automatic run(int div, int tks, int p_lo, int p_hi, int ab, int rs, int spur,
                     int b_lo, int b_hi, int pd_lo, int pd_hi, int n);
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        divideby = DW'(div);
        ticks    = CW'(tks);
      end
      start = (k == 0) || (k == spur);
      pause = (k >= p_lo) && (k <= p_hi);
      abort = (k == ab);
      reset = (k == rs);
      if (k >= 1) begin
        chk("busy", int'(busy), int'((k >= b_lo) && (k <= b_hi)));
        chk("paused", int'(paused), int'((k >= pd_lo) && (k <= pd_hi)));
      end
      next_cycle();
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_paused"}, int'(paused), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_remaining"}, int'(remaining), 0);
  endtask

  int x;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    pause    = 1'b0;
    abort    = 1'b0;
    divideby = '0;
    ticks    = '0;
    repeat (3) next_cycle();
    reset = 1'b0;
    next_cycle();
    chk_idle_outputs("reset");

    // 3 clocks per tick, 4 ticks; spurious start in RUN at cycle 5
    x = cyc;
    expect_ev(K_TICK, x + 3, 4);
    expect_ev(K_TICK, x + 6, 3);
    expect_ev(K_TICK, x + 9, 2);
    expect_ev(K_TICK, x + 12, 1);
    expect_ev(K_DONE, x + 13, 0);
    run(3, 4, -1, -2, -1, -1, 5, 1, 12, -1, -2, 14);
    chk_idle_outputs("after_3x4");

    // divide by 1, 2 ticks; start during DONE (cycle 3) ignored
    x = cyc;
    expect_ev(K_TICK, x + 1, 2);
    expect_ev(K_TICK, x + 2, 1);
    expect_ev(K_DONE, x + 3, 0);
    run(1, 2, -1, -2, -1, -1, 3, 1, 2, -1, -2, 5);

    // pause held in cycles 4..8 delays later ticks by 5; start in PAUSE ignored
    x = cyc;
    expect_ev(K_TICK, x + 3, 4);
    expect_ev(K_TICK, x + 11, 3);
    expect_ev(K_TICK, x + 14, 2);
    expect_ev(K_TICK, x + 17, 1);
    expect_ev(K_DONE, x + 18, 0);
    run(3, 4, 4, 8, -1, -1, 6, 1, 17, 5, 9, 20);

    // abort in cycle 7 of a 3x4 run, then a fresh start one cycle later
    x = cyc;
    expect_ev(K_TICK, x + 3, 4);
    expect_ev(K_TICK, x + 6, 3);
    run(3, 4, -1, -2, 7, -1, -1, 1, 7, -1, -2, 8);
    chk_idle_outputs("after_abort");
    x = cyc;
    expect_ev(K_TICK, x + 1, 1);
    expect_ev(K_DONE, x + 2, 0);
    run(1, 1, -1, -2, -1, -1, -1, 1, 1, -1, -2, 4);

    // rejected starts: divideby 0 then ticks 0
    x = cyc;
    expect_ev(K_ERR, x + 1, 0);
    expect_ev(K_ERR, x + 2, 0);
    start = 1'b1; divideby = 6'd0; ticks = 8'd4;
    next_cycle();
    chk("err_busy1", int'(busy), 0);
    start = 1'b1; divideby = 6'd3; ticks = 8'd0;
    next_cycle();
    chk("err_busy2", int'(busy), 0);
    start = 1'b0;
    next_cycle();
    chk("err_busy3", int'(busy), 0);
    next_cycle();

    // reset asserted in cycle 5 of a 3x4 run
    x = cyc;
    expect_ev(K_TICK, x + 3, 4);
    run(3, 4, -1, -2, -1, 5, -1, 1, 5, -1, -2, 9);
    chk_idle_outputs("after_reset");

    repeat (3) next_cycle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
